// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_multi clock divider / tick generator.
package clk_div_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned HALF_W_DEF = 27;

  // Half-period in clk_50m cycles that yields the requested output frequency.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned DEFAULT_HALF_DEF = half_for_hz(5);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, reloadable divisor with pending slot, divided clock and tick.
// Optional CLK_DIV_SYNC_RESTART_EN adds a sync_restart input for phase alignment.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned HALF_W       = HALF_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [HALF_W-1:0] wr_half,
`ifdef CLK_DIV_SYNC_RESTART_EN
  input  logic              sync_restart,
`endif
  output logic              clk_out,
  output logic              tick
);

  logic [HALF_W-1:0] r_cnt;
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_pending;
  logic              r_pend_valid;
  logic              r_clk_out;
  logic              r_tick;
  logic              w_term;
  logic              w_restart;

`ifdef CLK_DIV_SYNC_RESTART_EN
  assign w_restart = sync_restart;
`else
  assign w_restart = 1'b0;
`endif

  assign w_term = (r_cnt == (r_half - HALF_W'(1)));

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_half       <= HALF_W'(DEFAULT_HALF);
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_restart) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        if (r_pend_valid) begin
          r_half       <= r_pending;
          r_pend_valid <= 1'b0;
        end
      end else if (en) begin
        if (w_term) begin
          r_cnt     <= '0;
          r_clk_out <= ~r_clk_out;
          r_tick    <= 1'b1;
          if (r_pend_valid) begin
            r_half       <= r_pending;
            r_pend_valid <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + HALF_W'(1);
        end
      end else if (r_pend_valid) begin
        r_half       <= r_pending;
        r_pend_valid <= 1'b0;
        r_cnt        <= '0;
      end
      // A write landing on a wrap cycle is kept for the following wrap.
      if (wr) begin
        r_pending    <= wr_half;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a registered config write port (ack/err).
// Optional CLK_DIV_SYNC_RESTART_EN adds sync_restart to phase-align all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned HALF_W       = HALF_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [HALF_W-1:0] cfg_half,
`ifdef CLK_DIV_SYNC_RESTART_EN
  input  logic              sync_restart,
`endif
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic              w_ok;
  logic [NUM_CH-1:0] w_wr;
  logic              r_ack;
  logic              r_err;

  assign w_ok = (cfg_half != '0) && (32'(cfg_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_wr && w_ok && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .HALF_W       (HALF_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk_50m      (clk_50m),
      .rst          (rst),
      .en           (ch_en[g]),
      .wr           (w_wr[g]),
      .wr_half      (cfg_half),
`ifdef CLK_DIV_SYNC_RESTART_EN
      .sync_restart (sync_restart),
`endif
      .clk_out      (clk_out[g]),
      .tick         (tick[g])
    );
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= cfg_wr && w_ok;
      r_err <= cfg_wr && !w_ok;
    end
  end

  assign cfg_ack = r_ack;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed table-driven bench for clk_div_multi (NUM_CH=2, DEFAULT_HALF=4).
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned HALF_W = 27;
  localparam int unsigned CH_W   = 2;

  logic              clk_50m = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [HALF_W-1:0] cfg_half;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLK_DIV_SYNC_RESTART_EN
  logic              sync_restart;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH       (NUM_CH),
    .HALF_W       (HALF_W),
    .DEFAULT_HALF (4),
    .CH_W         (CH_W)
  ) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .ch_en        (ch_en),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_half     (cfg_half),
`ifdef CLK_DIV_SYNC_RESTART_EN
    .sync_restart (sync_restart),
`endif
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct {
    logic [1:0]  en;
    logic        wr;
    logic [1:0]  ch;
    logic [26:0] half;
    logic [1:0]  out;
    logic [1:0]  tk;
    logic        ack;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [1:0] en, input logic wr, input logic [1:0] ch,
                   input logic [26:0] half, input logic [1:0] out, input logic [1:0] tk,
                   input logic ack, input logic err);
    vec_t r;
    r.en = en; r.wr = wr; r.ch = ch; r.half = half;
    r.out = out; r.tk = tk; r.ack = ack; r.err = err;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] c_out, c_tk;
    rst = 1'b1; ch_en = 2'b11; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLK_DIV_SYNC_RESTART_EN
    sync_restart = 1'b0;
`endif

    // en, wr, ch, half, clk_out, tick, ack, err
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);  // 1
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);
    v(2'b11,0,0,0, 2'b11,2'b11,0,0);  // 4 first toggle
    v(2'b11,0,0,0, 2'b11,2'b00,0,0);
    v(2'b11,1,0,2, 2'b11,2'b00,1,0);  // 6 write ch0 half=2 at cnt=1
    v(2'b11,0,0,0, 2'b11,2'b00,0,0);
    v(2'b11,0,0,0, 2'b00,2'b11,0,0);  // 8 ch0 applies 2
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);
    v(2'b11,0,0,0, 2'b01,2'b01,0,0);  // 10
    v(2'b11,0,0,0, 2'b01,2'b00,0,0);
    v(2'b11,0,0,0, 2'b10,2'b11,0,0);
    v(2'b11,0,0,0, 2'b10,2'b00,0,0);
    v(2'b11,0,0,0, 2'b11,2'b01,0,0);
    v(2'b11,1,0,0, 2'b11,2'b00,0,1);  // 15 half=0 rejected
    v(2'b11,1,3,5, 2'b00,2'b11,0,1);  // 16 ch=3 rejected
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);
    v(2'b11,0,0,0, 2'b01,2'b01,0,0);  // 18
    v(2'b01,0,0,0, 2'b01,2'b00,0,0);  // 19 ch1 disabled at cnt=2
    v(2'b01,0,0,0, 2'b00,2'b01,0,0);
    v(2'b01,0,0,0, 2'b00,2'b00,0,0);
    v(2'b01,0,0,0, 2'b01,2'b01,0,0);
    v(2'b01,0,0,0, 2'b01,2'b00,0,0);
    v(2'b01,0,0,0, 2'b00,2'b01,0,0);
    v(2'b01,0,0,0, 2'b00,2'b00,0,0);
    v(2'b01,0,0,0, 2'b01,2'b01,0,0);
    v(2'b01,0,0,0, 2'b01,2'b00,0,0);
    v(2'b01,0,0,0, 2'b00,2'b01,0,0);  // 28
    v(2'b11,0,0,0, 2'b00,2'b00,0,0);  // 29 re-enabled
    v(2'b11,0,0,0, 2'b11,2'b11,0,0);  // 30 ch1 toggles 2 cycles later
    v(2'b11,1,1,6, 2'b11,2'b00,1,0);  // 31 ch1 half=6
    v(2'b11,1,1,3, 2'b10,2'b01,1,0);  // 32 ch1 half=3 overwrites
    v(2'b11,0,0,0, 2'b10,2'b00,0,0);
    v(2'b11,0,0,0, 2'b01,2'b11,0,0);  // 34 ch1 applies 3
    v(2'b11,0,0,0, 2'b01,2'b00,0,0);
    v(2'b11,0,0,0, 2'b00,2'b01,0,0);
    v(2'b11,0,0,0, 2'b10,2'b10,0,0);  // 37 ch1 half=3 wrap

    #2;
    chk("reset clk_out", 32'(clk_out), 0);
    chk("reset tick", 32'(tick), 0);
    chk("reset ack", 32'(cfg_ack), 0);
    chk("reset err", 32'(cfg_err), 0);
    #15 rst = 1'b0;

    foreach (tbl[i]) begin
      ch_en = tbl[i].en; cfg_wr = tbl[i].wr; cfg_ch = tbl[i].ch; cfg_half = tbl[i].half;
      step();
      chk($sformatf("row%0d clk_out", i + 1), 32'(clk_out), 32'(tbl[i].out));
      chk($sformatf("row%0d tick", i + 1), 32'(tick), 32'(tbl[i].tk));
      chk($sformatf("row%0d ack", i + 1), 32'(cfg_ack), 32'(tbl[i].ack));
      chk($sformatf("row%0d err", i + 1), 32'(cfg_err), 32'(tbl[i].err));
    end

    // Async reset with a pending write on ch1; pending must be discarded.
    ch_en = 2'b11; cfg_wr = 1'b1; cfg_ch = 1; cfg_half = 7;
    step();
    chk("pre-reset ack", 32'(cfg_ack), 1);
    cfg_wr = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async rst clk_out", 32'(clk_out), 0);
    chk("async rst tick", 32'(tick), 0);
    chk("async rst ack", 32'(cfg_ack), 0);
    #1 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) chk("post-rst e3 clk_out", 32'(clk_out), 0);
      if (k == 4) chk("post-rst e4 clk_out", 32'(clk_out), 3);
      if (k == 4) chk("post-rst e4 tick", 32'(tick), 3);
      if (k == 7) chk("post-rst e7 tick", 32'(tick), 0);
      if (k == 8) chk("post-rst e8 clk_out", 32'(clk_out), 0);
      if (k == 8) chk("post-rst e8 tick", 32'(tick), 3);
    end

    // Disabled ch0 applies half=1 on the following cycle, then runs at clk/2.
    ch_en = 2'b10; cfg_wr = 1'b1; cfg_ch = 0; cfg_half = 1;
    step();
    chk("dis-wr ack", 32'(cfg_ack), 1);
    chk("dis-wr tick0", 32'(tick[0]), 0);
    cfg_wr = 1'b0;
    step();
    chk("dis-apply clk_out0", 32'(clk_out[0]), 0);
    chk("dis-apply tick0", 32'(tick[0]), 0);
    ch_en = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("half1 c%0d clk_out0", k), 32'(clk_out[0]), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("half1 c%0d tick0", k), 32'(tick[0]), 1);
    end

    // Write to ch1 on its terminal-count cycle: takes effect one wrap later.
    rst = 1'b1;
    #2 rst = 1'b0;
    ch_en = 2'b11;
    for (int k = 0; k < 3; k++) step();
    cfg_wr = 1'b1; cfg_ch = 1; cfg_half = 2;
    c_out = 7'b1001111;  // edges 10..4 (bit0 = edge 4)
    c_tk  = 7'b1010001;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        chk("tc-wr ack", 32'(cfg_ack), 1);
        cfg_wr = 1'b0;
      end
      chk($sformatf("tc-wr e%0d clk_out1", k + 4), 32'(clk_out[1]), 32'(c_out[k]));
      chk($sformatf("tc-wr e%0d tick1", k + 4), 32'(tick[1]), 32'(c_tk[k]));
    end

`ifdef CLK_DIV_SYNC_RESTART_EN
    // ch0: half 4, cnt 2, out 0; ch1: half 2, cnt 0, out 1.
    sync_restart = 1'b1; cfg_wr = 1'b1; cfg_ch = 0; cfg_half = 3;
    step();
    chk("sync clk_out", 32'(clk_out), 0);
    chk("sync tick", 32'(tick), 0);
    chk("sync ack", 32'(cfg_ack), 1);
    sync_restart = 1'b0; cfg_wr = 1'b0;
    step();
    step();
    chk("sync+2 clk_out", 32'(clk_out), 2);
    step();
    step();
    chk("sync+4 clk_out", 32'(clk_out), 1);
    chk("sync+4 tick", 32'(tick), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, runtime-programmable, multi-channel clock divider / tick generator on the clk_50m domain.
- Each channel produces a 50%-duty divided output and a one-cycle tick strobe per output edge.
- Half-period is reloadable through a simple write port, with glitch-free switch-over.
- Serves as the common rate source for display scan, key debounce, blink and timekeeping logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- HALF_W, 27, width of half-period counter and divisor registers.
- DEFAULT_HALF, 5_000_000, reset half-period in clk_50m cycles; 5 Hz output at 50 MHz.
- CH_W, $clog2(NUM_CH) (min 1), width of channel select.

Ports:
- clk_50m  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- cfg_wr  input  1  one-cycle write strobe.
- cfg_ch  input  CH_W  target channel of write.
- cfg_half  input  HALF_W  new half-period in cycles.
- cfg_ack  output  1  one-cycle pulse: write accepted.
- cfg_err  output  1  one-cycle pulse: write rejected.
- clk_out  output  NUM_CH  divided clock per channel, registered.
- tick  output  NUM_CH  one-cycle strobe coincident with each clk_out toggle.

Behaviour:
- Reset (async, rst=1): cnt=0, half=DEFAULT_HALF, pending cleared, clk_out=0, tick=0, cfg_ack=0, cfg_err=0, all channels.
- Per channel, ch_en=1:
  - cnt increments each cycle.
  - When cnt==half-1: next cycle cnt=0, clk_out toggles, tick=1 for exactly that cycle.
  - Output period = 2*half cycles.
  - half=1: clk_out toggles every cycle (clk/2); tick continuously high.
- ch_en=0: cnt, clk_out held; tick=0. Re-enable resumes counting from held cnt.
- Config write (cfg_wr=1):
  - Rejected if cfg_half==0 or cfg_ch>=NUM_CH: cfg_err=1 next cycle, no state change.
  - Otherwise cfg_ack=1 next cycle; value stored in pending[cfg_ch] with pend_valid set.
  - Registered response; latency 1 cycle; back-to-back writes every cycle allowed.
- Pending apply:
  - ch_en=1: at the terminal-count cycle (cnt==half-1), half<=pending and pend_valid cleared. No partial periods; the current half-period completes with the old value.
  - ch_en=0: applied on the next cycle, cnt<=0, clk_out unchanged.
- Second write to same channel before apply: overwrites pending; only the latest is applied.
- Write arriving in the same cycle as terminal count: the current wrap uses the old pending (if any); the new value becomes pending for the next wrap.
- Reset mid-operation: all state returns to reset values immediately; a pending write is discarded.
- Counter arithmetic is unsigned HALF_W; cnt never exceeds half-1. Compare is ==; wrap resets to 0, no overflow path.

Optional Feature:
- Macro: CLK_DIV_SYNC_RESTART_EN.
- Defined: adds input sync_restart (1 bit). When high in a cycle, next cycle every channel gets:
  - cnt=0, clk_out=0, tick=0;
  - any pending half applied immediately.
  - This aligns the phases of all channels.
  - sync_restart takes priority over terminal count. A cfg write in the same cycle is still acked and stays pending.
- Not defined: port absent; channels only phase-align via reset.

Decomposition:
- Package clk_div_pkg:
  - HALF_W default;
  - DEFAULT_HALF;
  - CLK_HZ=50_000_000;
  - helper constant function half_for_hz(hz)=CLK_HZ/(2*hz).
- Sub-module clk_div_chan: one channel (cnt, half, pending, pend_valid, clk_out, tick).
- Top-level clk_div_multi: generate loop of NUM_CH instances, plus write decode and ack/err logic.

Test Plan:
- NUM_CH=2, DEFAULT_HALF=4, release rst, ch_en=11 -> clk_out toggles every 4 cycles on both channels, period 8; tick pulses 1 cycle at each toggle.
- Write ch0 half=2 mid-period at cnt=1 -> cfg_ack after 1 cycle; ch0 completes its 4-cycle half, then period 4; ch1 unaffected.
- Write half=0, then cfg_ch=3 with NUM_CH=2 -> cfg_err pulses each time; half unchanged; no ack.
- ch_en[1]=0 for 10 cycles at cnt=2 -> clk_out[1] held, tick[1]=0; after re-enable, toggle occurs 2 cycles later.
- Two writes to ch1 (half=6, then half=3) before wrap -> only 3 is applied at next terminal count.
- Assert rst mid-period with pending write -> outputs 0 immediately; after release, period 8 (DEFAULT_HALF); with CLK_DIV_SYNC_RESTART_EN, a sync_restart pulse zeroes both channels in the same cycle.
